// File: rtl/char_buffer_reader.sv
// ---------------------------------------------------------------------------
// char_buffer_reader
//
// Purpose:
//   Drains the decrypted-character buffer (BUF_LEN words starting at
//   BASE_ADDR in data RAM) and streams the low byte of each word out over a
//   valid/ready byte interface. The RAM port is borrowed through a
//   request/grant pair, so the processor keeps the port whenever this block
//   is not granted. With STOP_ON_NUL set, a 0x00 byte ends the transfer
//   early and is not emitted.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse that begins a drain (honoured only when idle)
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse when a transfer completes
//   char_count  bytes emitted in the current or last transfer
//   mem_req     request for the RAM port
//   mem_gnt     RAM port granted this cycle
//   mem_addr    RAM word address, meaningful while mem_req is high
//   mem_rdata   RAM read data, valid one cycle after a granted request
//   out_data    character byte
//   out_valid   out_data is valid
//   out_ready   downstream accepts the byte
// ---------------------------------------------------------------------------
module char_buffer_reader #(
  parameter logic [11:0] BASE_ADDR   = 12'd1500,
  parameter int unsigned BUF_LEN     = 108,
  parameter bit          STOP_ON_NUL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  char_count,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [11:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  // Index of the last buffer entry; accepting it ends the transfer.
  localparam logic [6:0] LAST_IDX = 7'(BUF_LEN - 1);

  state_t      state_q, state_d;
  logic [6:0]  index_q, index_d;
  logic [6:0]  char_count_q, char_count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_req_q, mem_req_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  // Only the low byte of each RAM word carries a character.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  // Next-state logic. Every output is a flop, so outputs for a state are
  // set up on the edge that enters it (e.g. mem_req/mem_addr are loaded
  // when moving into REQ, out_valid when moving into OUT).
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    char_count_d = char_count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_REQ;
          index_d      = 7'd0;
          char_count_d = 7'd0;
          busy_d       = 1'b1;
          mem_req_d    = 1'b1;
          mem_addr_d   = BASE_ADDR;
        end
      end

      S_REQ: begin
        // Address is held until the grant arrives.
        if (mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end

      S_WAIT: begin
        out_data_d = mem_rdata[7:0];
        if (STOP_ON_NUL && (mem_rdata[7:0] == 8'h00)) begin
          state_d = S_FIN;
        end else begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          char_count_d = char_count_q + 7'd1;
          index_d      = index_q + 7'd1;
          if (index_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = BASE_ADDR + 12'(index_q) + 12'd1;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer on the spot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      index_q      <= 7'd0;
      char_count_q <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 12'd0;
      out_data_q   <= 8'd0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      char_count_q <= char_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign char_count = char_count_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_char_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_char_buffer_reader
//
// Drives char_buffer_reader with a RAM model and randomized grant/ready
// behaviour. The expected byte stream is computed from the buffer contents
// and pushed into a queue; a monitor pops and compares every accepted byte.
// ---------------------------------------------------------------------------
module tb_char_buffer_reader;

  localparam int BASE = 1500;
  localparam int LEN  = 108;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [6:0]  char_count;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  out_data;
  logic        out_valid;

  char_buffer_reader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .char_count (char_count),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Edge counter: after rising edge k (and before edge k+1) cycle == k.
  always @(posedge clock) cycle <= cycle + 1;

  // RAM model: data for a granted address appears one cycle later,
  // otherwise the read bus carries junk.
  logic [31:0] mem [0:4095];
  always @(posedge clock) begin
    if (mem_req && mem_gnt) mem_rdata <= mem[mem_addr];
    else                    mem_rdata <= $urandom;
  end

  logic [7:0]  exp_q[$];
  int          exp_count = 0;
  int          gnt_mode = 0;
  int          ready_mode = 0;
  int          stall_left = 0;
  bit          stall_armed = 1'b0;
  int          done_count = 0;
  int          done_cycle = 0;
  int          start_edge = 0;
  logic [11:0] last_addr = 12'd0;
  logic [11:0] first_addr = 12'd0;
  bit          first_pending = 1'b0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  // Reference model: walk the buffer, stop at the first NUL, and queue
  // every byte the reader is expected to emit.
  task automatic buildExpected();
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < LEN; i++) begin
      b = mem[BASE + i][7:0];
      if (b == 8'h00) break;
      exp_q.push_back(b);
    end
    exp_count = exp_q.size();
  endtask

  // Load a buffer pattern and rebuild the expected stream:
  // 0 = 'A'+(i%26), 1 = "HELP" then NUL, 2 = random bytes with optional NUL.
  task automatic applyStimulus(input int pattern);
    int pos;
    for (int i = 0; i < LEN; i++)
      mem[BASE + i] = {24'($urandom), 8'(8'h41 + (i % 26))};
    if (pattern == 1) begin
      mem[BASE + 0] = 32'h0000_0048;
      mem[BASE + 1] = 32'h0000_0045;
      mem[BASE + 2] = 32'h0000_004C;
      mem[BASE + 3] = 32'h0000_0050;
      mem[BASE + 4] = 32'h0000_0000;
    end else if (pattern == 2) begin
      for (int i = 0; i < LEN; i++)
        mem[BASE + i] = {24'($urandom), 8'($urandom_range(1, 255))};
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, LEN - 1);
        mem[BASE + pos] = {24'($urandom), 8'h00};
      end
    end
    buildExpected();
  endtask

  // Pulse start for one cycle and note which edge samples it.
  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    start_edge = cycle + 1;
    @(negedge clock);
    start = 1'b0;
    #1;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait for the next done pulse within a cycle budget.
  task automatic waitDone(input int budget);
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (done_count == d0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done pulse, expected one within %0d cycles", budget);
    end
  endtask

  // Grant and ready drivers, updated on the falling edge. The stall mode
  // holds the grant off for ten cycles on the request for index 5 and
  // checks that the request stays put meanwhile.
  initial begin
    forever begin
      @(negedge clock);
      case (gnt_mode)
        1: mem_gnt = 1'($urandom_range(0, 1));
        2: begin
          if (stall_armed && mem_req && mem_addr == 12'(BASE + 5)) begin
            stall_armed = 1'b0;
            stall_left = 10;
          end
          if (stall_left > 0) begin
            mem_gnt = 1'b0;
            checkOutput("stall_req", 32'(mem_req), 32'd1);
            checkOutput("stall_addr", 32'(mem_addr), 32'(BASE + 5));
            stall_left--;
          end else begin
            mem_gnt = 1'b1;
          end
        end
        default: mem_gnt = 1'b1;
      endcase
      case (ready_mode)
        1: out_ready = (cycle % 4 == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        3: out_ready = (char_count != 7'd50);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: samples just after the falling edge, i.e. the values the next
  // rising edge will act on. Pops the scoreboard on every handshake, checks
  // that a stalled byte stays put, and validates each done pulse.
  initial begin
    bit         prev_valid;
    bit         prev_ready;
    bit         prev_done;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_done  = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          checkOutput("valid_hold", 32'(out_valid), 32'd1);
          checkOutput("data_hold", 32'(out_data), 32'(prev_data));
        end
        if (mem_req && first_pending) begin
          first_addr = mem_addr;
          first_pending = 1'b0;
        end
        if (mem_req && mem_gnt) last_addr = mem_addr;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_byte: got 0x%0h, expected no further bytes", out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("byte", 32'(out_data), 32'(e));
          end
        end
        if (done) begin
          done_count++;
          done_cycle = cycle;
          checkOutput("done_single", 32'(prev_done), 32'd0);
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          checkOutput("count_at_done", 32'(char_count), 32'(exp_count));
          checkOutput("bytes_left", 32'(exp_q.size()), 32'd0);
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_done  = done;
      end
    end
  end

  // Main sequence of directed and randomized transfers.
  initial begin
    int n;
    int d0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", 32'(char_count), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Full drain at full rate.
    $display("[TB] full drain, grant and ready always high");
    applyStimulus(0);
    first_pending = 1'b1;
    pulseStart();
    waitDone(1000);
    checkOutput("full_latency", 32'(done_cycle - start_edge), 32'd325);
    checkOutput("full_first_addr", 32'(first_addr), 32'(BASE));
    checkOutput("full_last_addr", 32'(last_addr), 32'(BASE + LEN - 1));

    // Throttled downstream.
    $display("[TB] drain with ready 1 high / 3 low");
    ready_mode = 1;
    applyStimulus(0);
    pulseStart();
    waitDone(3000);
    ready_mode = 0;

    // Grant withheld on index 5.
    $display("[TB] grant stall on index 5");
    gnt_mode = 2;
    stall_armed = 1'b1;
    stall_left = 0;
    applyStimulus(0);
    pulseStart();
    waitDone(1000);
    checkOutput("stall_taken", 32'(stall_armed), 32'd0);
    gnt_mode = 0;

    // Early stop on NUL.
    $display("[TB] HELP then NUL");
    applyStimulus(1);
    pulseStart();
    waitDone(200);
    checkOutput("nul_count", 32'(char_count), 32'd4);

    // Reset while holding a byte at index 50, then restart.
    $display("[TB] reset during OUT at index 50");
    ready_mode = 3;
    applyStimulus(0);
    pulseStart();
    n = 0;
    do begin
      @(negedge clock);
      #2;
      n++;
    end while (!(char_count == 7'd50 && out_valid) && n < 500);
    checkOutput("reached_idx50", 32'(char_count), 32'd50);
    d0 = done_count;
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count", 32'(char_count), 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("abort_no_done", 32'(done_count), 32'(d0));
    reset = 1'b1;
    ready_mode = 0;
    applyStimulus(0);
    first_pending = 1'b1;
    pulseStart();
    checkOutput("restart_count", 32'(char_count), 32'd0);
    waitDone(1000);
    checkOutput("restart_first_addr", 32'(first_addr), 32'(BASE));

    // Start pulsed again mid-transfer must be ignored.
    $display("[TB] second start at index 20");
    applyStimulus(0);
    d0 = done_count;
    pulseStart();
    n = 0;
    while (char_count != 7'd20 && n < 500) begin
      @(negedge clock);
      #2;
      n++;
    end
    pulseStart();
    waitDone(1000);
    repeat (10) @(negedge clock);
    #2;
    checkOutput("single_done", 32'(done_count - d0), 32'd1);
    checkOutput("no_restart", 32'(busy), 32'd0);

    // Randomized contents, grant and ready.
    $display("[TB] randomized transfers");
    gnt_mode = 1;
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2);
      pulseStart();
      waitDone(5000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
